// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch stage with a DEPTH-entry return buffer.
// It generates sequential PCs and issues them to a fixed one-cycle-latency
// instruction memory. Returned words are buffered with their PCs and handed
// to decode over a valid/ready handshake. A branch redirect flushes the
// buffer and any in-flight word, then fetching restarts at the target.
// Optional feature: define IF_FETCH_PERF_EN to enable the perf_fetch_cnt and
// perf_flush_cnt counters. When it is not defined, both ports read 0 and no
// counter flops are built.
module if_fetch_queue #(
  parameter int unsigned         WORD_LEN    = 32,
  parameter int unsigned         DEPTH       = 4,
  parameter logic [WORD_LEN-1:0] RESET_PC    = '0,
  parameter int unsigned         INSTR_BYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_pc,
  input  logic [WORD_LEN-1:0] br_offset,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] out_pc,
  output logic [WORD_LEN-1:0] out_instr,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_flush_cnt
);

  localparam int unsigned         PTR_W = $clog2(DEPTH);
  localparam int unsigned         CNT_W = PTR_W + 1;
  localparam logic [WORD_LEN-1:0] STEP  = WORD_LEN'(INSTR_BYTES);

  // Fetch address generator and the single outstanding request tracker.
  logic [WORD_LEN-1:0] fetch_pc;
  logic [WORD_LEN-1:0] inflight_pc;
  logic                inflight;

  // Return buffer: separate PC and instruction storage, pointers and count.
  logic [WORD_LEN-1:0] pc_mem    [DEPTH];
  logic [WORD_LEN-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;

  // Per-cycle control decisions.
  logic [CNT_W-1:0]    occupancy;
  logic                issue;
  logic                push;
  logic                pop;
  logic [WORD_LEN-1:0] target;

  // Decide issue, push, pop and the redirect target for this cycle.
  always_comb begin
    occupancy = count + CNT_W'(inflight);
    // Buffer slots are reserved for words still in flight. This keeps the
    // buffer from overflowing while decode stalls.
    issue     = rst && !br_taken && (occupancy < CNT_W'(DEPTH));
    // A word that returns during a redirect cycle belongs to the old stream.
    push      = inflight && !br_taken;
    out_valid = !br_taken && (count != '0);
    pop       = out_valid && out_ready;
    target    = br_pc + STEP + (br_offset * STEP);
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign out_pc    = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];

  // Advance the fetch PC on each issue and reload it on a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
    end else if (br_taken) begin
      fetch_pc <= target;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + STEP;
      end
    end
  end

  // Buffer pointers and occupancy count. A redirect clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (br_taken) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Buffer storage. Each entry is written with the PC it was fetched from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[PTR_W'(i)]    <= '0;
        instr_mem[PTR_W'(i)] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  // Count delivered instructions and redirect cycles. Both wrap at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pop)      fetch_cnt <= fetch_cnt + 32'd1;
      if (br_taken) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed stimulus for if_fetch_queue. A queue-based
// behavioural model is checked against the DUT on every cycle, and literal
// hand-computed expectations pin the model's behaviour. A second instance
// starts near the top of the address space so the PC wrap can be observed.
module tb_if_fetch_queue;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
`ifdef IF_FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, br_taken, out_ready;
  logic [W-1:0] br_pc, br_offset, imem_rdata;
  logic         imem_req, out_valid;
  logic [W-1:0] imem_addr, out_pc, out_instr;
  logic [31:0]  perf_fetch_cnt, perf_flush_cnt;

  logic         b_br_taken, b_out_ready;
  logic [W-1:0] b_br_pc, b_br_offset, b_imem_rdata;
  logic         b_imem_req, b_out_valid;
  logic [W-1:0] b_imem_addr, b_out_pc, b_out_instr;
  logic [31:0]  b_perf_fetch_cnt, b_perf_flush_cnt;

  int tests = 0;
  int fails = 0;

  if_fetch_queue #(.WORD_LEN(W), .DEPTH(DEPTH), .RESET_PC(32'h0), .INSTR_BYTES(4)) dut (
    .clk(clk), .rst(rst), .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt));

  if_fetch_queue #(.WORD_LEN(W), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .INSTR_BYTES(4)) dut_wrap (
    .clk(clk), .rst(rst), .br_taken(b_br_taken), .br_pc(b_br_pc), .br_offset(b_br_offset),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr),
    .perf_fetch_cnt(b_perf_fetch_cnt), .perf_flush_cnt(b_perf_flush_cnt));

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory models: the word for an address is returned one cycle
  // after the request. When there was no request, junk is driven instead.
  logic         a_req_q = 1'b0, b_req_q = 1'b0;
  logic [W-1:0] a_addr_q = '0, b_addr_q = '0;
  always @(negedge clk) begin
    a_req_q  = imem_req;   a_addr_q = imem_addr;
    b_req_q  = b_imem_req; b_addr_q = b_imem_addr;
  end
  always @(posedge clk) begin
    #1;
    imem_rdata   = a_req_q ? imem_word(a_addr_q) : 32'hDEAD_BEEF;
    b_imem_rdata = b_req_q ? imem_word(b_addr_q) : 32'hDEAD_BEEF;
  end

  // Behavioural model: a queue of delivered-to-be words plus the single
  // pending return. It is checked at every negedge and then advanced.
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  ent_t        m_ent;
  logic [31:0] m_fpc, m_pend_pc;
  bit          m_pend, e_req, e_valid;
  logic [31:0] m_fetch, m_flush;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_req",    32'(imem_req),  32'd0);
      chk("rst_valid",  32'(out_valid), 32'd0);
      chk("rst_pc",     out_pc,         32'd0);
      chk("rst_instr",  out_instr,      32'd0);
      chk("rst_pfetch", perf_fetch_cnt, 32'd0);
      chk("rst_pflush", perf_flush_cnt, 32'd0);
      mq.delete();
      m_fpc = 32'h0; m_pend = 1'b0; m_pend_pc = '0; m_fetch = '0; m_flush = '0;
    end else begin
      e_req   = !br_taken && ((mq.size() + int'(m_pend)) < DEPTH);
      e_valid = !br_taken && (mq.size() != 0);
      chk("m_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("m_addr", imem_addr, m_fpc);
      chk("m_valid", 32'(out_valid), 32'(e_valid));
      if (e_valid) begin
        chk("m_pc",    out_pc,    mq[0].pc);
        chk("m_instr", out_instr, mq[0].instr);
      end
      chk("m_pfetch", perf_fetch_cnt, PERF ? m_fetch : 32'd0);
      chk("m_pflush", perf_flush_cnt, PERF ? m_flush : 32'd0);
      if (br_taken) begin
        mq.delete();
        m_pend = 1'b0;
        m_fpc  = br_pc + 32'd4 + br_offset * 32'd4;
        m_flush = m_flush + 32'd1;
      end else begin
        if (e_valid && out_ready) begin
          void'(mq.pop_front());
          m_fetch = m_fetch + 32'd1;
        end
        if (m_pend) begin
          m_ent.pc = m_pend_pc; m_ent.instr = imem_word(m_pend_pc);
          mq.push_back(m_ent);
        end
        m_pend = e_req;
        if (e_req) begin
          m_pend_pc = m_fpc;
          m_fpc     = m_fpc + 32'd4;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [15:0] ready_pat;
  int          nreq;

  initial begin
    rst = 1'b0; br_taken = 1'b0; br_pc = '0; br_offset = '0; out_ready = 1'b1;
    b_br_taken = 1'b0; b_br_pc = '0; b_br_offset = '0; b_out_ready = 1'b1;
    imem_rdata = '0; b_imem_rdata = '0;

    // Reset state, then the first fetches after release.
    repeat (2) cyc();
    mid();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_req",   32'(imem_req),  32'd0);
    cyc(); rst = 1'b1;
    mid();
    chk("a0_req", 32'(imem_req), 32'd1);
    chk("a0_addr", imem_addr, 32'h0);
    chk("w0_addr", b_imem_addr, 32'hFFFF_FFF8);
    cyc(); mid();
    chk("a1_addr", imem_addr, 32'h4);
    chk("a1_valid", 32'(out_valid), 32'd0);
    chk("w1_addr", b_imem_addr, 32'hFFFF_FFFC);
    cyc(); mid();
    chk("a2_addr", imem_addr, 32'h8);
    chk("a2_valid", 32'(out_valid), 32'd1);
    chk("a2_pc", out_pc, 32'h0);
    chk("a2_instr", out_instr, 32'hC0DE_0000);
    chk("w2_addr", b_imem_addr, 32'h0);
    chk("w2_pc", b_out_pc, 32'hFFFF_FFF8);
    chk("w2_instr", b_out_instr, 32'h3F21_FFF8);
    cyc(); mid();
    chk("a3_pc", out_pc, 32'h4);
    chk("w3_pc", b_out_pc, 32'hFFFF_FFFC);
    cyc(); mid();
    chk("w4_pc", b_out_pc, 32'h0);
    chk("w4_instr", b_out_instr, 32'hC0DE_0000);
    repeat (3) cyc();

    // Single-cycle redirect to 0x20 + 4 + 3*4 = 0x30.
    br_taken = 1'b1; br_pc = 32'h20; br_offset = 32'd3;
    mid();
    chk("br1_valid", 32'(out_valid), 32'd0);
    chk("br1_req", 32'(imem_req), 32'd0);
    cyc(); br_taken = 1'b0;
    mid();
    chk("br1_next_req", 32'(imem_req), 32'd1);
    chk("br1_next_addr", imem_addr, 32'h30);
    chk("br1_drop", 32'(out_valid), 32'd0);
    cyc(); mid();
    chk("br1_gap", 32'(out_valid), 32'd0);
    cyc(); mid();
    chk("br1_first_valid", 32'(out_valid), 32'd1);
    chk("br1_first_pc", out_pc, 32'h30);
    chk("br1_first_instr", out_instr, 32'hC0DE_0030);
    cyc(); mid();
    chk("br1_second_pc", out_pc, 32'h34);
    cyc();

    // Negative offset: 0x40 + 4 - 8 = 0x3C.
    br_taken = 1'b1; br_pc = 32'h40; br_offset = 32'hFFFF_FFFE;
    cyc(); br_taken = 1'b0;
    mid();
    chk("br2_addr", imem_addr, 32'h3C);
    repeat (4) cyc();

    // Redirect held for three cycles. The last target, 0x100 + 4, wins.
    br_taken = 1'b1; br_pc = 32'h80; br_offset = 32'd1;
    cyc(); br_pc = 32'h90; br_offset = 32'd5;
    cyc(); br_pc = 32'h100; br_offset = 32'd0;
    mid();
    chk("brh_valid", 32'(out_valid), 32'd0);
    cyc(); br_taken = 1'b0;
    mid();
    chk("brh_addr", imem_addr, 32'h104);
    repeat (3) cyc();

    // Irregular ready pattern, with a redirect in the middle.
    ready_pat = 16'b1011_0010_0111_0001;
    for (int i = 0; i < 16; i++) begin
      out_ready = ready_pat[i];
      br_taken  = (i == 9);
      br_pc     = 32'h200; br_offset = 32'd2;
      cyc();
    end
    br_taken = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();

    // Stall from reset: exactly DEPTH requests, head held, then gapless drain.
    rst = 1'b0;
    cyc(); rst = 1'b1; out_ready = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (imem_req) nreq++;
      cyc();
    end
    chk("stall_reqs", 32'(nreq), 32'd4);
    mid();
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_pc", out_pc, 32'h0);
    cyc(); out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_pc", out_pc, 32'(i * 4));
      cyc();
    end

    // Reset while the buffer is full: outputs clear at once, fetch restarts.
    out_ready = 1'b0;
    repeat (8) cyc();
    mid();
    chk("full_valid", 32'(out_valid), 32'd1);
    cyc(); rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_req", 32'(imem_req), 32'd0);
    cyc(); rst = 1'b1; out_ready = 1'b1;
    mid();
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_req", 32'(imem_req), 32'd1);
    cyc();

    // Counter segment: exactly 5 transfers and 2 redirect cycles.
    rst = 1'b0;
    cyc(); rst = 1'b1; out_ready = 1'b0;
    repeat (8) cyc();
    out_ready = 1'b1;
    repeat (5) cyc();
    out_ready = 1'b0; br_taken = 1'b1; br_pc = 32'h0; br_offset = 32'd0;
    repeat (2) cyc();
    br_taken = 1'b0;
    mid();
    chk("perf_fetch", perf_fetch_cnt, PERF ? 32'd5 : 32'd0);
    chk("perf_flush", perf_flush_cnt, PERF ? 32'd2 : 32'd0);
    chk("wrap_perf_flush", b_perf_flush_cnt, 32'd0);
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
